// File: rtl/priority_code_pkg.sv
// Shared definitions for the 16-input priority-encoder link (encoder and decoder sides).
package priority_code_pkg;

  localparam int unsigned CODE_W   = 8;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned ONEHOT_W = 16;

  localparam logic [CODE_W-1:0] NONE_CODE = 8'hF0;

  typedef struct packed {
    logic             none;
    logic [IDX_W-1:0] idx;
  } pc_entry_t;

  // A code is well-formed if it is a 0..15 index or the "no input active" marker.
  function automatic logic is_malformed(input logic [CODE_W-1:0] code,
                                        input logic [CODE_W-1:0] none_code = NONE_CODE);
    return (code[CODE_W-1:IDX_W] != '0) && (code != none_code);
  endfunction

endpackage

// File: rtl/pc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO of decoded link entries, wrap-bit pointers.
module pc_sync_fifo
  import priority_code_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pc_entry_t        wr_data,
  input  logic             pop,
  output pc_entry_t        rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [LVL_W-1:0] level_c
);

  pc_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign level_c   = LVL_W'(wr_ptr - rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_c   = (wr_ptr == rd_ptr);
  assign rd_data_c = mem[rd_ptr[AW-1:0]];
  assign do_push   = push && !full_c;
  assign do_pop    = pop && !empty_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/priority_code_decoder.sv
// Receive side of the priority-encoder link: classify codes, buffer them, re-expand to one-hot.
module priority_code_decoder
  import priority_code_pkg::*;
#(
  parameter int unsigned        DEPTH     = 4,
  parameter logic [CODE_W-1:0]  NONE_CODE = priority_code_pkg::NONE_CODE,
  parameter int unsigned        CNT_W     = 8,
  localparam int unsigned       LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic                out_none,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LVL_W-1:0]    fifo_level,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                err_sticky,
  input  logic                err_clr
);

  logic       accept;
  logic       malformed;
  logic       push;
  logic       pop;
  logic       full_c;
  logic       empty_c;
  pc_entry_t  wr_entry;
  pc_entry_t  rd_entry_c;
  logic [CNT_W-1:0] err_cnt_d;
  logic             err_sticky_d;

  // Ready depends only on registered FIFO state, never on out_ready.
  assign in_ready  = !rst && !full_c;
  assign accept    = in_valid && in_ready;
  assign malformed = is_malformed(in_code, NONE_CODE);
  assign push      = accept && !malformed;
  assign pop       = !empty_c && (!out_valid || out_ready);

  assign wr_entry.none = (in_code == NONE_CODE);
  assign wr_entry.idx  = in_code[IDX_W-1:0];

  pc_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wr_data   (wr_entry),
    .pop       (pop),
    .rd_data_c (rd_entry_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .level_c   (fifo_level)
  );

  // Output register: load on pop, drop valid once consumed with nothing behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_none   <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_onehot <= rd_entry_c.none ? '0 : (ONEHOT_W'(1) << rd_entry_c.idx);
      out_none   <= rd_entry_c.none;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Clear takes effect before a same-cycle error is counted.
  always_comb begin
    err_cnt_d    = err_cnt;
    err_sticky_d = err_sticky;
    if (err_clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end
    if (accept && malformed) begin
      err_sticky_d = 1'b1;
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      err_cnt    <= err_cnt_d;
      err_sticky <= err_sticky_d;
    end
  end

endmodule

// File: tb/tb_priority_code_decoder.sv
// Directed self-checking bench for priority_code_decoder.
module tb_priority_code_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_code;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      out_onehot;
  logic             out_none;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sticky;
  logic             err_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_code_decoder #(.DEPTH(DEPTH), .NONE_CODE(8'hF0), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_none   (out_none),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_code = 8'h00; out_ready = 1'b1; err_clr = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (out_onehot !== 16'h0000 || out_none !== 1'b0) begin errors++; $display("FAIL reset_data: got %h/%b expected 0000/0", out_onehot, out_none); end
    checks++; if (err_cnt !== '0 || err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err: got %h/%b expected 00/0", err_cnt, err_sticky); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_code = 8'h0E;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got out_valid %b expected 0", out_valid); end
    in_code = 8'h00;
    step();
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h4000) begin errors++; $display("FAIL basic_w0: got %b/%h expected 1/4000", out_valid, out_onehot); end
    in_code = 8'h07;
    step();
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0001) begin errors++; $display("FAIL basic_w1: got %b/%h expected 1/0001", out_valid, out_onehot); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0080) begin errors++; $display("FAIL basic_w2: got %b/%h expected 1/0080", out_valid, out_onehot); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_none();
    in_valid = 1'b1; in_code = 8'hF0;
    step();
    in_code = 8'h0F;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0000 || out_none !== 1'b1) begin errors++; $display("FAIL none_word: got %b/%h/%b expected 1/0000/1", out_valid, out_onehot, out_none); end
    step();
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h8000 || out_none !== 1'b0) begin errors++; $display("FAIL idx15_word: got %b/%h/%b expected 1/8000/0", out_valid, out_onehot, out_none); end
    step();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_code = 8'(i + 1);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (acc != 5) begin errors++; $display("FAIL bp_accepted: got %0d expected 5", acc); end
    checks++; if (fifo_level !== LVL_W'(4) || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got level %0d ready %b expected 4/0", fifo_level, in_ready); end
    step(); step();
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0002) begin errors++; $display("FAIL bp_hold: got %b/%h expected 1/0002", out_valid, out_onehot); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_onehot !== 16'(1 << (j + 1))) begin
        errors++; $display("FAIL bp_drain%0d: got %b/%h expected 1/%h", j, out_valid, out_onehot, 16'(1 << (j + 1)));
      end
      step();
    end
    checks++; if (out_valid !== 1'b0 || fifo_level !== '0) begin errors++; $display("FAIL bp_empty: got %b/%0d expected 0/0", out_valid, fifo_level); end
  endtask

  task automatic test_malformed();
    logic [7:0]  codes [5] = '{8'h01, 8'h23, 8'hF1, 8'h10, 8'h02};
    logic [15:0] got [$];
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = codes[i];
      if (out_valid) got.push_back(out_onehot);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) got.push_back(out_onehot);
      step();
    end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL mal_word_count: got %0d expected 2", got.size()); end
    else begin
      checks++; if (got[0] !== 16'h0002 || got[1] !== 16'h0004) begin errors++; $display("FAIL mal_words: got %h,%h expected 0002,0004", got[0], got[1]); end
    end
    checks++; if (err_cnt !== 8'h03 || err_sticky !== 1'b1) begin errors++; $display("FAIL mal_err: got %h/%b expected 03/1", err_cnt, err_sticky); end
    in_valid = 1'b1; in_code = 8'hFF; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    checks++; if (err_cnt !== 8'h01 || err_sticky !== 1'b1) begin errors++; $display("FAIL clr_with_err: got %h/%b expected 01/1", err_cnt, err_sticky); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_cnt !== 8'h00 || err_sticky !== 1'b0) begin errors++; $display("FAIL clr_only: got %h/%b expected 00/0", err_cnt, err_sticky); end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; in_code = 8'hAB;
    repeat (254) step();
    checks++; if (err_cnt !== 8'hFE) begin errors++; $display("FAIL sat_254: got %h expected FE", err_cnt); end
    repeat (46) step();
    in_valid = 1'b0;
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_300: got %h expected FF", err_cnt); end
    checks++; if (out_valid !== 1'b0 || fifo_level !== '0) begin errors++; $display("FAIL sat_no_output: got %b/%0d expected 0/0", out_valid, fifo_level); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] codes [5] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h99};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = codes[i];
      step();
    end
    in_valid = 1'b0;
    checks++; if (fifo_level !== LVL_W'(3) || out_valid !== 1'b1 || out_onehot !== 16'h0008 || err_cnt !== 8'h01) begin
      errors++; $display("FAIL pre_reset: got lvl %0d v %b oh %h err %h expected 3/1/0008/01", fifo_level, out_valid, out_onehot, err_cnt);
    end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_level !== '0 || err_cnt !== '0 || out_onehot !== 16'h0000 || in_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset: got v %b lvl %0d err %h oh %h rdy %b expected all 0", out_valid, fifo_level, err_cnt, out_onehot, in_ready);
    end
    step();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_code = 8'h09;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_latency: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0200 || out_none !== 1'b0) begin errors++; $display("FAIL post_rst_word: got %b/%h/%b expected 1/0200/0", out_valid, out_onehot, out_none); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_none();
    test_backpressure();
    test_malformed();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
